// File: rtl/axi_decerr_responder_pkg.sv
// Shared SoC definitions used by the default-slave error responder.
// Holds the slave-side ID width, the DECERR code and the responder state encodings.
package ariane_soc;

   localparam int unsigned IdWidthSlave = 5;

   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

endpackage

// File: rtl/axi_decerr_responder.sv
// Crossbar default slave: accepts any AXI transaction into an unmapped hole and answers DECERR.
// Write and read paths are independent FSMs; ready outputs are purely state-decoded.
module axi_decerr_responder
   import ariane_soc::*;
#(
   parameter int unsigned           ID_WIDTH      = IdWidthSlave,
   parameter int unsigned           DATA_WIDTH    = 64,
   parameter logic [DATA_WIDTH-1:0] RDATA_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic [ID_WIDTH-1:0]   aw_id_i,

   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   input  logic                  w_last_i,

   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   output logic [ID_WIDTH-1:0]   b_id_o,
   output logic [1:0]            b_resp_o,

   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   input  logic [ID_WIDTH-1:0]   ar_id_i,
   input  logic [7:0]            ar_len_i,

   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o
);

   w_state_e            w_state_q, w_state_d;
   logic [ID_WIDTH-1:0] b_id_q;

   r_state_e            r_state_q, r_state_d;
   logic [ID_WIDTH-1:0] r_id_q;
   logic [7:0]          r_len_q;
   logic [7:0]          r_cnt_q;

   // Write path: the ID is captured on the AW handshake and held until B completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         b_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         if ((w_state_q == W_IDLE) && aw_valid_i) begin
            b_id_q <= aw_id_i;
         end
      end
   end

   always_comb begin
      w_state_d  = w_state_q;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) begin
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign b_id_o   = b_id_q;
   assign b_resp_o = RESP_DECERR;

   // Read path: the beat counter stops on the last beat, so a 256-beat burst never wraps it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         if ((r_state_q == R_IDLE) && ar_valid_i) begin
            r_id_q  <= ar_id_i;
            r_len_q <= ar_len_i;
            r_cnt_q <= '0;
         end else if ((r_state_q == R_DATA) && r_ready_i && !r_last_o) begin
            r_cnt_q <= r_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      r_state_d  = r_state_q;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            ar_ready_o = 1'b1;
            if (ar_valid_i) begin
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            r_valid_o = 1'b1;
            r_last_o  = (r_cnt_q == r_len_q);
            if (r_ready_i && r_last_o) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign r_id_o   = r_id_q;
   assign r_data_o = RDATA_PATTERN;
   assign r_resp_o = RESP_DECERR;

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Scoreboard bench for the DECERR default slave: stimulus pushes expected B/R beats,
// a negedge monitor pops and compares them and also checks latency and stall stability.
module tb_axi_decerr_responder;
   import ariane_soc::*;

   localparam int          IDW = 5;
   localparam logic [63:0] PAT = 64'hDEAD_BEEF_DEAD_BEEF;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           aw_valid_i = 1'b0;
   logic           aw_ready_o;
   logic [IDW-1:0] aw_id_i = '0;
   logic           w_valid_i = 1'b0;
   logic           w_ready_o;
   logic           w_last_i = 1'b0;
   logic           b_valid_o;
   logic           b_ready_i = 1'b0;
   logic [IDW-1:0] b_id_o;
   logic [1:0]     b_resp_o;
   logic           ar_valid_i = 1'b0;
   logic           ar_ready_o;
   logic [IDW-1:0] ar_id_i = '0;
   logic [7:0]     ar_len_i = '0;
   logic           r_valid_o;
   logic           r_ready_i = 1'b0;
   logic [IDW-1:0] r_id_o;
   logic [63:0]    r_data_o;
   logic [1:0]     r_resp_o;
   logic           r_last_o;

   int total = 0;
   int bad   = 0;
   int rBeats = 0;

   logic [IDW-1:0] bq[$];
   logic [IDW:0]   rq[$];

   axi_decerr_responder dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .aw_valid_i (aw_valid_i),
      .aw_ready_o (aw_ready_o),
      .aw_id_i    (aw_id_i),
      .w_valid_i  (w_valid_i),
      .w_ready_o  (w_ready_o),
      .w_last_i   (w_last_i),
      .b_valid_o  (b_valid_o),
      .b_ready_i  (b_ready_i),
      .b_id_o     (b_id_o),
      .b_resp_o   (b_resp_o),
      .ar_valid_i (ar_valid_i),
      .ar_ready_o (ar_ready_o),
      .ar_id_i    (ar_id_i),
      .ar_len_i   (ar_len_i),
      .r_valid_o  (r_valid_o),
      .r_ready_i  (r_ready_i),
      .r_id_o     (r_id_o),
      .r_data_o   (r_data_o),
      .r_resp_o   (r_resp_o),
      .r_last_o   (r_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, midway between input changes and active edges.
   initial begin
      bit             pendB = 0, pendR = 0, bStall = 0, rStall = 0;
      logic [IDW-1:0] bIdPrev = '0, rIdPrev = '0;
      logic           rLastPrev = 1'b0;
      logic [63:0]    rDataPrev = '0;
      logic [IDW-1:0] eb;
      logic [IDW:0]   er;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            pendB = 0; pendR = 0; bStall = 0; rStall = 0;
         end else begin
            if (pendB) checkOutput("b_latency", 64'(b_valid_o), 64'd1);
            if (pendR) checkOutput("r_latency", 64'(r_valid_o), 64'd1);
            if (bStall) begin
               checkOutput("b_hold_valid", 64'(b_valid_o), 64'd1);
               checkOutput("b_hold_id", 64'(b_id_o), 64'(bIdPrev));
            end
            if (rStall) begin
               checkOutput("r_hold_valid", 64'(r_valid_o), 64'd1);
               checkOutput("r_hold_id", 64'(r_id_o), 64'(rIdPrev));
               checkOutput("r_hold_data", r_data_o, rDataPrev);
               checkOutput("r_hold_last", 64'(r_last_o), 64'(rLastPrev));
            end
            if (b_valid_o && b_ready_i) begin
               if (bq.size() == 0) begin
                  checkOutput("b_unexpected", 64'(bq.size()), 64'd1);
               end else begin
                  eb = bq.pop_front();
                  checkOutput("b_id", 64'(b_id_o), 64'(eb));
                  checkOutput("b_resp", 64'(b_resp_o), 64'd3);
               end
            end
            if (r_valid_o && r_ready_i) begin
               if (rq.size() == 0) begin
                  checkOutput("r_unexpected", 64'(rq.size()), 64'd1);
               end else begin
                  er = rq.pop_front();
                  rBeats++;
                  checkOutput("r_id", 64'(r_id_o), 64'(er[IDW-1:0]));
                  checkOutput("r_data", r_data_o, PAT);
                  checkOutput("r_resp", 64'(r_resp_o), 64'd3);
                  checkOutput("r_last", 64'(r_last_o), 64'(er[IDW]));
               end
            end
            pendB     = w_valid_i && w_ready_o && w_last_i;
            pendR     = ar_valid_i && ar_ready_o;
            bStall    = b_valid_o && !b_ready_i;
            rStall    = r_valid_o && !r_ready_i;
            bIdPrev   = b_id_o;
            rIdPrev   = r_id_o;
            rDataPrev = r_data_o;
            rLastPrev = r_last_o;
         end
      end
   end

   task automatic sendAw(input logic [IDW-1:0] id);
      bit hs;
      int n = 0;
      aw_valid_i = 1'b1;
      aw_id_i    = id;
      bq.push_back(id);
      do begin
         @(negedge clk_i); hs = aw_ready_o;
         @(posedge clk_i); #1; n++;
      end while (!hs && n < 50);
      checkOutput("aw_handshake", 64'(hs), 64'd1);
      aw_valid_i = 1'b0;
   endtask

   task automatic sendW(input int beats);
      bit hs;
      for (int i = 0; i < beats; i++) begin
         int n = 0;
         w_valid_i = 1'b1;
         w_last_i  = (i == beats - 1);
         do begin
            @(negedge clk_i); hs = w_ready_o;
            @(posedge clk_i); #1; n++;
         end while (!hs && n < 50);
         checkOutput("w_handshake", 64'(hs), 64'd1);
      end
      w_valid_i = 1'b0;
      w_last_i  = 1'b0;
   endtask

   task automatic sendAr(input logic [IDW-1:0] id, input logic [7:0] len);
      bit hs;
      int n = 0;
      ar_valid_i = 1'b1;
      ar_id_i    = id;
      ar_len_i   = len;
      for (int k = 0; k <= int'(len); k++) rq.push_back({(k == int'(len)), id});
      do begin
         @(negedge clk_i); hs = ar_ready_o;
         @(posedge clk_i); #1; n++;
      end while (!hs && n < 50);
      checkOutput("ar_handshake", 64'(hs), 64'd1);
      ar_valid_i = 1'b0;
   endtask

   task automatic waitDrain(input int budget, input bit toggleR);
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < budget) begin
         @(posedge clk_i); #1; n++;
         if (toggleR) r_ready_i = ~r_ready_i;
      end
      checkOutput("drain_b", 64'(bq.size()), 64'd0);
      checkOutput("drain_r", 64'(rq.size()), 64'd0);
   endtask

   task automatic applyStimulus();
      int base;
      int n;
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_b_valid", 64'(b_valid_o), 64'd0);
      checkOutput("rst_r_valid", 64'(r_valid_o), 64'd0);
      checkOutput("rst_w_ready", 64'(w_ready_o), 64'd0);
      checkOutput("rst_r_last", 64'(r_last_o), 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("post_rst_aw_ready", 64'(aw_ready_o), 64'd1);
      checkOutput("post_rst_ar_ready", 64'(ar_ready_o), 64'd1);
      checkOutput("post_rst_w_ready", 64'(w_ready_o), 64'd0);
      checkOutput("post_rst_b_valid", 64'(b_valid_o), 64'd0);
      checkOutput("post_rst_r_valid", 64'(r_valid_o), 64'd0);
      checkOutput("post_rst_b_id", 64'(b_id_o), 64'd0);
      checkOutput("post_rst_r_id", 64'(r_id_o), 64'd0);

      // W beats offered while idle must not be taken
      w_valid_i = 1'b1; w_last_i = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         checkOutput("w_idle_ready", 64'(w_ready_o), 64'd0);
      end
      @(posedge clk_i); #1;
      w_valid_i = 1'b0; w_last_i = 1'b0;
      checkOutput("w_idle_no_b", 64'(b_valid_o), 64'd0);

      // Single write burst of four beats
      b_ready_i = 1'b1;
      sendAw(5'h13);
      sendW(4);
      waitDrain(20, 1'b0);

      // Read burst of four beats
      r_ready_i = 1'b1;
      sendAr(5'h07, 8'd3);
      waitDrain(20, 1'b0);

      // Single-beat read
      sendAr(5'h02, 8'd0);
      waitDrain(10, 1'b0);

      // Maximum-length read with ready toggling every cycle
      sendAr(5'h1c, 8'd255);
      waitDrain(1200, 1'b1);
      r_ready_i = 1'b1;
      @(posedge clk_i); #1;
      checkOutput("len255_ar_ready", 64'(ar_ready_o), 64'd1);

      // Simultaneous AW and AR, with B stalled for ten cycles
      b_ready_i  = 1'b0;
      aw_valid_i = 1'b1; aw_id_i = 5'h05; bq.push_back(5'h05);
      ar_valid_i = 1'b1; ar_id_i = 5'h11; ar_len_i = 8'd2;
      for (int k = 0; k <= 2; k++) rq.push_back({(k == 2), 5'h11});
      @(negedge clk_i);
      checkOutput("dual_aw_ready", 64'(aw_ready_o), 64'd1);
      checkOutput("dual_ar_ready", 64'(ar_ready_o), 64'd1);
      @(posedge clk_i); #1;
      aw_valid_i = 1'b0; ar_valid_i = 1'b0;
      checkOutput("dual_aw_taken", 64'(aw_ready_o), 64'd0);
      checkOutput("dual_ar_taken", 64'(ar_ready_o), 64'd0);
      sendW(1);
      repeat (10) begin @(posedge clk_i); #1; end
      checkOutput("dual_r_done", 64'(rq.size()), 64'd0);
      checkOutput("dual_b_pending", 64'(b_valid_o), 64'd1);
      b_ready_i = 1'b1;
      waitDrain(10, 1'b0);

      // Reset in the middle of a read burst
      base = rBeats;
      sendAr(5'h15, 8'd7);
      n = 0;
      while (rBeats < base + 2 && n < 30) begin @(posedge clk_i); #1; n++; end
      checkOutput("mid_burst_beats", 64'(rBeats - base), 64'd2);
      rst_i = 1'b1; r_ready_i = 1'b0;
      rq.delete();
      @(posedge clk_i); #1;
      checkOutput("mid_rst_r_valid", 64'(r_valid_o), 64'd0);
      checkOutput("mid_rst_r_last", 64'(r_last_o), 64'd0);
      checkOutput("mid_rst_r_id", 64'(r_id_o), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("mid_rel_ar_ready", 64'(ar_ready_o), 64'd1);
      checkOutput("mid_rel_r_valid", 64'(r_valid_o), 64'd0);
      r_ready_i = 1'b1;
      sendAr(5'h0a, 8'd1);
      waitDrain(10, 1'b0);
   endtask

   initial begin
      applyStimulus();
      repeat (2) @(posedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/axi_decerr_responder.md
AXI_DECERR_RESPONDER -- requirements
Module: axi_decerr_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default ariane_soc::IdWidthSlave (5), meaning AXI ID width on the slave side of the crossbar.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning R data width.
REQ-003 SHALL have parameter RDATA_PATTERN, default 64'hDEAD_BEEF_DEAD_BEEF, meaning the constant returned on every R beat.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset, synchronous and active-high.
REQ-006 aw_valid_i  in  1  write address valid.
REQ-007 aw_ready_o  out  1  write address ready.
REQ-008 aw_id_i  in  ID_WIDTH  write transaction ID.
REQ-009 w_valid_i  in  1  write data valid.
REQ-010 w_ready_o  out  1  write data ready.
REQ-011 w_last_i  in  1  last write beat.
REQ-012 b_valid_o  out  1  write response valid.
REQ-013 b_ready_i  in  1  write response ready.
REQ-014 b_id_o  out  ID_WIDTH  write response ID.
REQ-015 b_resp_o  out  2  write response code.
REQ-016 ar_valid_i  in  1  read address valid.
REQ-017 ar_ready_o  out  1  read address ready.
REQ-018 ar_id_i  in  ID_WIDTH  read transaction ID.
REQ-019 ar_len_i  in  8  burst length minus one.
REQ-020 r_valid_o  out  1  read data valid.
REQ-021 r_ready_i  in  1  read data ready.
REQ-022 r_id_o  out  ID_WIDTH  read data ID.
REQ-023 r_data_o  out  DATA_WIDTH  read data; always RDATA_PATTERN.
REQ-024 r_resp_o  out  2  read response code.
REQ-025 r_last_o  out  1  last read beat.

Function
REQ-026 The block SHALL answer every transaction with DECERR (2'b11) on b_resp_o and r_resp_o, whatever the address; it is the crossbar default slave for holes between the ariane_soc regions.
REQ-027 The write path SHALL be a 3-state FSM: W_IDLE, W_DATA, W_RESP.
- W_IDLE: aw_ready_o=1; on an aw handshake, latch aw_id_i and go to W_DATA.
- W_DATA: w_ready_o=1; discard beats; on a w handshake with w_last_i=1, go to W_RESP.
- W_RESP: b_valid_o=1 with the latched ID; on a b handshake, go to W_IDLE.
REQ-028 The read path SHALL be a 2-state FSM, R_IDLE and R_DATA, independent of the write path.
- R_IDLE: ar_ready_o=1; on an ar handshake, latch ar_id_i and ar_len_i, clear the 8-bit beat counter, go to R_DATA.
- R_DATA: r_valid_o=1; r_last_o=(counter==latched len); each r handshake increments the counter; the handshake with r_last_o returns to R_IDLE.
REQ-029 Latency SHALL be: b_valid_o asserted the cycle after the w_last handshake; r_valid_o asserted the cycle after the ar handshake.
REQ-030 ready outputs SHALL depend only on state, never combinationally on a valid input.
REQ-031 While valid is high and ready is low, all B/R payload outputs SHALL stay stable.
REQ-032 ar_len_i=0 SHALL give one beat with r_last_o=1; ar_len_i=255 SHALL give 256 beats; the counter SHALL never wrap within a burst.
REQ-033 The write beat count SHALL be determined solely by w_last_i; W beats arriving in W_IDLE or W_RESP SHALL not be accepted.
REQ-034 Simultaneous aw and ar handshakes SHALL both be accepted in the same cycle.

Reset
REQ-035 On rst_i=1 at a clock edge, both FSMs SHALL go to their IDLE state and the counter, latched IDs and len SHALL clear to 0, including in the middle of a burst.
REQ-036 During reset and in the cycle after it, b_valid_o=0, r_valid_o=0, w_ready_o=0 and r_last_o=0, and aw_ready_o/ar_ready_o SHALL be 1 from the first cycle after reset is released.

Structure
REQ-037 The DECERR constant, the write/read state enums, and the use of IdWidthSlave SHALL come from the ariane_soc package; there is no sub-module, and both paths are inline.

Verification
REQ-038 AW id=5'h13, 4 W beats with last on the 4th, b_ready=1 -> B id=5'h13 resp=2'b11 one cycle after the last beat.
REQ-039 AR id=5'h07 len=3, r_ready=1 -> 4 beats of 64'hDEAD_BEEF_DEAD_BEEF, resp=2'b11, r_last only on beat 4.
REQ-040 AR len=255 with r_ready toggling every cycle -> exactly 256 beats, payload stable during stalls, no counter wrap.
REQ-041 AW and AR in the same cycle, b_ready held low for 10 cycles -> the read burst completes unaffected and B is held stable until ready.
REQ-042 rst_i asserted at beat 2 of a len=7 burst -> r_valid_o=0 the next cycle, ar_ready_o=1 after release, and a new AR is served correctly.
